// File: rtl/button_event_gen.sv
// Per-channel button event generator: one pulse per press, plus optional auto-repeat
// paced by a shared 1 ms tick derived from the 1 kHz divider output.
`timescale 1ns/1ps

module button_event_gen #(
    parameter int                 N_BTN       = 5,
    parameter int                 HOLD_MS     = 500,
    parameter int                 REPEAT_MS   = 100,
    parameter logic [N_BTN-1:0]   REPEAT_MASK = 5'b00011
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_1kHz,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] pulse_out,
    output logic [N_BTN-1:0] held_out
);

    typedef enum logic [1:0] {
        ARMED,
        WAIT_REL,
        HOLD,
        REPEATING
    } state_e;

    localparam logic [9:0] HOLD_LAST = 10'(HOLD_MS - 1);
    localparam logic [9:0] REP_LAST  = 10'(REPEAT_MS - 1);
    localparam logic [9:0] CNT_MAX   = 10'd1023;

    logic khz_q;
    logic tick_en_q;
    logic ms_tick;

    // tick_en_q masks the first cycle after reset so a high clk_1kHz at release is not an edge.
    // NOTE: all state uses non-blocking assignments under an async reset; mixing in blocking
    // assignments here would make the result depend on simulator process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            khz_q     <= 1'b0;
            tick_en_q <= 1'b0;
        end else begin
            khz_q     <= clk_1kHz;
            tick_en_q <= 1'b1;
        end
    end

    assign ms_tick = clk_1kHz & ~khz_q & tick_en_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        state_e     state_q;
        logic [9:0] cnt_q;
        logic       pulse_q;
        logic       held_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= WAIT_REL;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
                held_q  <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                unique case (state_q)
                    WAIT_REL: begin
                        if (!btn_in[i]) state_q <= ARMED;
                    end
                    ARMED: begin
                        if (btn_in[i]) begin
                            state_q <= HOLD;
                            cnt_q   <= '0;
                            pulse_q <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (!btn_in[i]) begin
                            state_q <= ARMED;
                        end else if (ms_tick) begin
                            // Unmasked channels park at the terminal count and stay silent.
                            if (cnt_q == HOLD_LAST) begin
                                if (REPEAT_MASK[i]) begin
                                    state_q <= REPEATING;
                                    cnt_q   <= '0;
                                    pulse_q <= 1'b1;
                                    held_q  <= 1'b1;
                                end
                            end else if (cnt_q != CNT_MAX) begin
                                cnt_q <= cnt_q + 10'd1;
                            end
                        end
                    end
                    REPEATING: begin
                        // Release is checked first so it beats a coincident terminal tick.
                        if (!btn_in[i]) begin
                            state_q <= ARMED;
                            held_q  <= 1'b0;
                        end else if (ms_tick) begin
                            if (cnt_q == REP_LAST) begin
                                pulse_q <= 1'b1;
                                cnt_q   <= '0;
                            end else if (cnt_q != CNT_MAX) begin
                                cnt_q <= cnt_q + 10'd1;
                            end
                        end
                    end
                    default: state_q <= WAIT_REL;
                endcase
            end
        end

        assign pulse_out[i] = pulse_q;
        assign held_out[i]  = held_q;
    end

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen; clk_1kHz is compressed to a 10-clk period so
// each "ms" is 10 system clocks and long holds stay short in simulation.
`timescale 1ns/1ps

module tb_button_event_gen;

    localparam int N = 5;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         clk_1khz = 1'b0;
    logic [N-1:0] btn_in   = '0;
    logic [N-1:0] pulse_out;
    logic [N-1:0] held_out;

    int checks   = 0;
    int failures = 0;

    button_event_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_1kHz  (clk_1khz),
        .btn_in    (btn_in),
        .pulse_out (pulse_out),
        .held_out  (held_out)
    );

    always #5 clk = ~clk;

    // Rising edges at 2, 102, 202 ... land between a negedge and the following posedge.
    initial begin
        #2;
        forever begin
            clk_1khz = 1'b1;
            #50;
            clk_1khz = 1'b0;
            #50;
        end
    end

    int ticks = 0;
    always @(posedge clk_1khz) ticks++;

    int           pulse_total [N]     = '{default: 0};
    int           pulse_log   [N][16] = '{default: '{default: 0}};
    int           held_rise   [N]     = '{default: 0};
    int           held_cycles [N]     = '{default: 0};
    int           b2b_viol            = 0;
    logic [N-1:0] prev_p              = '0;
    logic [N-1:0] prev_h              = '0;

    always @(negedge clk) begin
        for (int c = 0; c < N; c++) begin
            if (pulse_out[c]) begin
                pulse_log[c][pulse_total[c] % 16] = ticks;
                pulse_total[c]++;
                if (prev_p[c]) b2b_viol++;
            end
            if (held_out[c]) begin
                held_cycles[c]++;
                if (!prev_h[c]) held_rise[c] = ticks;
            end
        end
        prev_p = pulse_out;
        prev_h = held_out;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic align_ms();
        @(posedge clk_1khz);
        step(1);
    endtask

    task automatic wait_until_tick(input int target, input string name);
        int guard = 0;
        while (ticks < target && guard < 100000) begin
            step(1);
            guard++;
        end
        if (ticks < target) begin
            failures++;
            $display("FAIL %s timeout: ticks=%0d required=%0d", name, ticks, target);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        btn_in = '0;
        step(3);
        checks++;
        if (pulse_out !== 5'b00000) begin
            failures++;
            $display("FAIL reset_pulse got=%b exp=%b", pulse_out, 5'b00000);
        end
        checks++;
        if (held_out !== 5'b00000) begin
            failures++;
            $display("FAIL reset_held got=%b exp=%b", held_out, 5'b00000);
        end
        @(posedge clk_1khz);
        #20;
        rst_n = 1'b1;
        step(4);
        checks++;
        if (pulse_out !== 5'b00000) begin
            failures++;
            $display("FAIL post_reset_pulse got=%b exp=%b", pulse_out, 5'b00000);
        end
    endtask

    task automatic test_single_press();
        int base, hbase, t;
        align_ms();
        base  = pulse_total[4];
        hbase = held_cycles[4];
        btn_in[4] = 1'b1;
        step(1);
        checks++;
        if (pulse_out !== 5'b10000) begin
            failures++;
            $display("FAIL single_latency got=%b exp=%b", pulse_out, 5'b10000);
        end
        step(1);
        checks++;
        if (pulse_out[4] !== 1'b0) begin
            failures++;
            $display("FAIL single_width got=%b exp=0", pulse_out[4]);
        end
        t = ticks + 3;
        wait_until_tick(t, "single_hold");
        btn_in[4] = 1'b0;
        step(3);
        checks++;
        if (pulse_total[4] - base !== 1) begin
            failures++;
            $display("FAIL single_count got=%0d exp=1", pulse_total[4] - base);
        end
        checks++;
        if (held_cycles[4] - hbase !== 0) begin
            failures++;
            $display("FAIL single_held got=%0d cycles exp=0", held_cycles[4] - hbase);
        end
    endtask

    task automatic test_hold_repeat();
        int base, p;
        int exp_off [5] = '{0, 500, 600, 700, 800};
        align_ms();
        base = pulse_total[0];
        p    = ticks;
        btn_in[0] = 1'b1;
        step(1);
        checks++;
        if (pulse_out !== 5'b00001) begin
            failures++;
            $display("FAIL repeat_press got=%b exp=%b", pulse_out, 5'b00001);
        end
        wait_until_tick(p + 800, "repeat_hold");
        step(2);
        checks++;
        if (held_out[0] !== 1'b1) begin
            failures++;
            $display("FAIL repeat_held_on got=%b exp=1", held_out[0]);
        end
        btn_in[0] = 1'b0;
        step(1);
        checks++;
        if (held_out[0] !== 1'b0) begin
            failures++;
            $display("FAIL repeat_held_off got=%b exp=0", held_out[0]);
        end
        checks++;
        if (pulse_total[0] - base !== 5) begin
            failures++;
            $display("FAIL repeat_count got=%0d exp=5", pulse_total[0] - base);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (pulse_log[0][(base + i) % 16] - p !== exp_off[i]) begin
                failures++;
                $display("FAIL repeat_time[%0d] got=%0d ms exp=%0d ms", i,
                         pulse_log[0][(base + i) % 16] - p, exp_off[i]);
            end
        end
        checks++;
        if (held_rise[0] - p !== 500) begin
            failures++;
            $display("FAIL repeat_held_rise got=%0d ms exp=500 ms", held_rise[0] - p);
        end
    endtask

    task automatic test_unmasked_hold();
        int base, hbase, p;
        align_ms();
        base  = pulse_total[3];
        hbase = held_cycles[3];
        p     = ticks;
        btn_in[3] = 1'b1;
        step(1);
        checks++;
        if (pulse_out !== 5'b01000) begin
            failures++;
            $display("FAIL unmasked_press got=%b exp=%b", pulse_out, 5'b01000);
        end
        wait_until_tick(p + 2000, "unmasked_hold");
        step(2);
        btn_in[3] = 1'b0;
        step(2);
        checks++;
        if (pulse_total[3] - base !== 1) begin
            failures++;
            $display("FAIL unmasked_count got=%0d exp=1", pulse_total[3] - base);
        end
        checks++;
        if (held_cycles[3] - hbase !== 0) begin
            failures++;
            $display("FAIL unmasked_held got=%0d cycles exp=0", held_cycles[3] - hbase);
        end
    endtask

    task automatic test_release_race();
        int base, p;
        align_ms();
        base = pulse_total[1];
        p    = ticks;
        btn_in[1] = 1'b1;
        step(1);
        checks++;
        if (pulse_out !== 5'b00010) begin
            failures++;
            $display("FAIL race_press got=%b exp=%b", pulse_out, 5'b00010);
        end
        wait_until_tick(p + 599, "race_hold");
        checks++;
        if (held_out[1] !== 1'b1) begin
            failures++;
            $display("FAIL race_held_on got=%b exp=1", held_out[1]);
        end
        // Release lands on the same clk as the tick that would end the 100 ms interval.
        @(posedge clk_1khz);
        btn_in[1] = 1'b0;
        step(3);
        checks++;
        if (pulse_total[1] - base !== 2) begin
            failures++;
            $display("FAIL race_count got=%0d exp=2", pulse_total[1] - base);
        end
        checks++;
        if (held_out[1] !== 1'b0) begin
            failures++;
            $display("FAIL race_held_off got=%b exp=0", held_out[1]);
        end
        btn_in[1] = 1'b1;
        step(1);
        checks++;
        if (pulse_out !== 5'b00010) begin
            failures++;
            $display("FAIL race_rearm got=%b exp=%b", pulse_out, 5'b00010);
        end
        btn_in[1] = 1'b0;
        step(2);
    endtask

    task automatic test_reset_held();
        int base;
        rst_n     = 1'b0;
        btn_in[2] = 1'b1;
        base      = pulse_total[2];
        step(3);
        rst_n = 1'b1;
        step(20);
        checks++;
        if (pulse_total[2] - base !== 0) begin
            failures++;
            $display("FAIL held_reset_count got=%0d exp=0", pulse_total[2] - base);
        end
        btn_in[2] = 1'b0;
        step(2);
        btn_in[2] = 1'b1;
        step(1);
        checks++;
        if (pulse_out !== 5'b00100) begin
            failures++;
            $display("FAIL held_reset_repress got=%b exp=%b", pulse_out, 5'b00100);
        end
        btn_in[2] = 1'b0;
        step(2);
        checks++;
        if (pulse_total[2] - base !== 1) begin
            failures++;
            $display("FAIL held_reset_total got=%0d exp=1", pulse_total[2] - base);
        end
    endtask

    task automatic test_concurrent_reset();
        int base0, base1, p;
        align_ms();
        base0 = pulse_total[0];
        base1 = pulse_total[1];
        p     = ticks;
        btn_in[1:0] = 2'b11;
        step(1);
        checks++;
        if (pulse_out !== 5'b00011) begin
            failures++;
            $display("FAIL concurrent_press got=%b exp=%b", pulse_out, 5'b00011);
        end
        wait_until_tick(p + 300, "concurrent_hold");
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (held_out !== 5'b00000 || pulse_out !== 5'b00000) begin
            failures++;
            $display("FAIL concurrent_abort got held=%b pulse=%b exp 00000/00000", held_out, pulse_out);
        end
        step(2);
        rst_n = 1'b1;
        wait_until_tick(p + 650, "concurrent_after");
        checks++;
        if (pulse_total[0] - base0 !== 1 || pulse_total[1] - base1 !== 1) begin
            failures++;
            $display("FAIL concurrent_count got=%0d/%0d exp=1/1",
                     pulse_total[0] - base0, pulse_total[1] - base1);
        end
        checks++;
        if (held_out !== 5'b00000) begin
            failures++;
            $display("FAIL concurrent_held got=%b exp=%b", held_out, 5'b00000);
        end
        btn_in[1:0] = 2'b00;
        step(2);
    endtask

    task automatic test_repeat_abort();
        int p;
        align_ms();
        p = ticks;
        btn_in[0] = 1'b1;
        wait_until_tick(p + 520, "abort_hold");
        checks++;
        if (held_out !== 5'b00001) begin
            failures++;
            $display("FAIL abort_held_on got=%b exp=%b", held_out, 5'b00001);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (held_out !== 5'b00000) begin
            failures++;
            $display("FAIL abort_held_drop got=%b exp=%b", held_out, 5'b00000);
        end
        step(2);
        rst_n     = 1'b1;
        btn_in[0] = 1'b0;
        step(3);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_hold_repeat();
        test_unmasked_hold();
        test_release_race();
        test_reset_held();
        test_concurrent_reset();
        test_repeat_abort();
        checks++;
        if (b2b_viol !== 0) begin
            failures++;
            $display("FAIL pulse_gap got=%0d adjacent pulses exp=0", b2b_viol);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
